// File: rtl/parking_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : parking_input_conditioner                                     |
// | Purpose  : Synchronizes and debounces raw passcode buttons and gate      |
// |            sensors, emits one-cycle button-press pulses, and tracks car  |
// |            direction through the gate with a timeout-guarded FSM.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module parking_input_conditioner #(
   parameter int DB_CYCLES      = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:1] Prs_raw,
   input  logic       Sens_a,
   input  logic       Sens_b,
   output logic [3:1] Prs,
   output logic       Car_in,
   output logic       Car_out,
   output logic       Gate_busy
);

   localparam int c_DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
   localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DB_CYCLES - 1);
   localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_WAIT_CLEAR = 3'd0,
      S_IDLE       = 3'd1,
      S_IN_A       = 3'd2,
      S_IN_AB      = 3'd3,
      S_IN_B       = 3'd4,
      S_OUT_B      = 3'd5,
      S_OUT_AB     = 3'd6,
      S_OUT_A      = 3'd7
   } gate_state_t;

   // Bits [2:0] are buttons 1..3, bit 3 is sensor a, bit 4 is sensor b.
   logic [4:0]        w_raw;
   logic [4:0]        r_sync1;
   logic [4:0]        r_sync2;
   logic [4:0]        w_db;
   logic [2:0]        r_btn_d;
   logic [2:0]        r_prs;
   logic              r_car_in;
   logic              r_car_out;
   gate_state_t       r_state;
   gate_state_t       w_next;
   logic              w_fin_in;
   logic              w_fin_out;
   logic              w_busy;
   logic [c_TO_W-1:0] r_to;
   logic              w_a;
   logic              w_b;

   assign w_raw = {Sens_b, Sens_a, Prs_raw};

   // Two-flop synchronizer on every asynchronous input.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_db
         logic              r_val;
         logic [c_DB_W-1:0] r_cnt;

         // Flip the debounced value only after DB_CYCLES consecutive disagreeing samples.
         always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
               r_val <= 1'b0;
               r_cnt <= '0;
            end else if (r_sync2[gi] == r_val) begin
               r_cnt <= '0;
            end else if (r_cnt == c_DB_LAST) begin
               r_val <= r_sync2[gi];
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign w_db[gi] = r_val;
      end
   endgenerate

   // Registered rising-edge detect on the debounced buttons.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_btn_d <= '0;
         r_prs   <= '0;
      end else begin
         r_btn_d <= w_db[2:0];
         r_prs   <= w_db[2:0] & ~r_btn_d;
      end
   end

   assign w_a = w_db[3];
   assign w_b = w_db[4];

   // Gate next-state decode; completion flags mark the final clearing step of a passage.
   always_comb begin
      w_next    = r_state;
      w_fin_in  = 1'b0;
      w_fin_out = 1'b0;
      case (r_state)
         S_WAIT_CLEAR: begin
            if (!w_a && !w_b) w_next = S_IDLE;
         end
         S_IDLE: begin
            if (w_a && !w_b)      w_next = S_IN_A;
            else if (!w_a && w_b) w_next = S_OUT_B;
            else if (w_a && w_b)  w_next = S_WAIT_CLEAR;
         end
         S_IN_A: begin
            if (w_b)       w_next = S_IN_AB;
            else if (!w_a) w_next = S_IDLE;
         end
         S_IN_AB: begin
            if (!w_a && w_b)       w_next = S_IN_B;
            else if (w_a && !w_b)  w_next = S_IN_A;
            else if (!w_a && !w_b) w_next = S_WAIT_CLEAR;
         end
         S_IN_B: begin
            if (w_a) begin
               w_next = S_IN_AB;
            end else if (!w_b) begin
               w_next   = S_IDLE;
               w_fin_in = 1'b1;
            end
         end
         S_OUT_B: begin
            if (w_a)       w_next = S_OUT_AB;
            else if (!w_b) w_next = S_IDLE;
         end
         S_OUT_AB: begin
            if (w_a && !w_b)       w_next = S_OUT_A;
            else if (!w_a && w_b)  w_next = S_OUT_B;
            else if (!w_a && !w_b) w_next = S_WAIT_CLEAR;
         end
         S_OUT_A: begin
            if (w_b) begin
               w_next = S_OUT_AB;
            end else if (!w_a) begin
               w_next    = S_IDLE;
               w_fin_out = 1'b1;
            end
         end
         default: w_next = S_WAIT_CLEAR;
      endcase
   end

   assign w_busy = (r_state != S_WAIT_CLEAR) && (r_state != S_IDLE);

   // Gate FSM state, dwell timer and registered car pulses.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= S_WAIT_CLEAR;
         r_to      <= '0;
         r_car_in  <= 1'b0;
         r_car_out <= 1'b0;
      end else begin
         r_car_in  <= w_fin_in;
         r_car_out <= w_fin_out;
         if (w_next != r_state) begin
            r_state <= w_next;
            r_to    <= '0;
         end else if (w_busy) begin
            if (r_to == c_TO_LAST) begin
               r_state <= S_WAIT_CLEAR;
               r_to    <= '0;
            end else begin
               r_to <= r_to + 1'b1;
            end
         end else begin
            r_to <= '0;
         end
      end
   end

   assign Prs       = r_prs;
   assign Car_in    = r_car_in;
   assign Car_out   = r_car_out;
   assign Gate_busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_parking_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_parking_input_conditioner                                  |
// | Purpose  : Self-checking bench: table-driven gate sequences, directed    |
// |            button/timeout/reset scenarios, and randomized stimulus       |
// |            compared against a behavioural model.                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_parking_input_conditioner;

   localparam int DB = 4;
   localparam int TO = 64;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [3:1] Prs_raw = '0;
   logic       Sens_a = 1'b0;
   logic       Sens_b = 1'b0;
   logic [3:1] Prs;
   logic       Car_in;
   logic       Car_out;
   logic       Gate_busy;

   parking_input_conditioner #(
      .DB_CYCLES      (DB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .Prs_raw   (Prs_raw),
      .Sens_a    (Sens_a),
      .Sens_b    (Sens_b),
      .Prs       (Prs),
      .Car_in    (Car_in),
      .Car_out   (Car_out),
      .Gate_busy (Gate_busy)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Inputs are remembered as a history of samples; an input's clean value
   // changes once its last DB synchronized samples all disagree with it.
   logic [4:0] m_hist [0:DB];
   logic [4:0] m_db, m_db_d, m_nd;
   logic [2:0] e_prs = '0;
   logic       e_in = 1'b0, e_out = 1'b0, e_busy = 1'b0;
   int         m_mode;      // 0 waiting for clear, 1 idle, 2 passage
   logic       m_dir_in;
   logic [1:0] m_stage;     // {first sensor, second sensor} in travel order
   int         m_t;
   logic       m_a, m_b, m_all;
   logic [1:0] m_p;

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int j = 0; j <= DB; j++) m_hist[j] = '0;
         m_db = '0; m_db_d = '0;
         e_prs = '0; e_in = 0; e_out = 0; e_busy = 0;
         m_mode = 0; m_dir_in = 0; m_stage = 2'b00; m_t = 0;
      end else begin
         e_prs = m_db[2:0] & ~m_db_d[2:0];
         e_in  = 0;
         e_out = 0;
         m_a   = m_db[3];
         m_b   = m_db[4];
         case (m_mode)
            0: if (!m_a && !m_b) m_mode = 1;
            1: begin
               if (m_a != m_b) begin
                  m_mode = 2; m_dir_in = m_a; m_stage = 2'b10; m_t = 0;
               end else if (m_a && m_b) m_mode = 0;
            end
            default: begin
               m_p = m_dir_in ? {m_a, m_b} : {m_b, m_a};
               if (m_p == 2'b00) begin
                  if (m_stage == 2'b01) begin
                     m_mode = 1;
                     if (m_dir_in) e_in = 1; else e_out = 1;
                  end else if (m_stage == 2'b10) m_mode = 1;
                  else m_mode = 0;
               end else if (m_stage != 2'b11 && m_p != m_stage) begin
                  m_stage = 2'b11; m_t = 0;
               end else if (m_stage == 2'b11 && m_p != 2'b11) begin
                  m_stage = m_p; m_t = 0;
               end else if (m_t == TO - 1) begin
                  m_mode = 0;
               end else begin
                  m_t++;
               end
            end
         endcase
         e_busy = (m_mode == 2);
         m_nd = m_db;
         for (int i = 0; i < 5; i++) begin
            m_all = 1;
            for (int j = 1; j <= DB; j++) if (m_hist[j][i] == m_db[i]) m_all = 0;
            if (m_all) m_nd[i] = ~m_db[i];
         end
         m_db_d = m_db;
         m_db   = m_nd;
         for (int j = DB; j > 0; j--) m_hist[j] = m_hist[j-1];
         m_hist[0] = {Sens_b, Sens_a, Prs_raw};
      end
   end

   // ---------------- monitors ----------------
   int cyc = 0;
   int cnt_p [1:3] = '{0, 0, 0};
   int cnt_in = 0, cnt_out = 0;
   int last_p1 = -1;

   always @(posedge CLK) cyc++;

   always @(negedge CLK) begin
      chk("model_prs",  int'(Prs),       int'(e_prs));
      chk("model_in",   int'(Car_in),    int'(e_in));
      chk("model_out",  int'(Car_out),   int'(e_out));
      chk("model_busy", int'(Gate_busy), int'(e_busy));
      chk("excl_in_out", int'(Car_in & Car_out), 0);
      for (int i = 1; i <= 3; i++) if (Prs[i]) cnt_p[i]++;
      if (Prs[1]) last_p1 = cyc;
      if (Car_in) cnt_in++;
      if (Car_out) cnt_out++;
   end

   // ---------------- gate vector table ----------------
   typedef struct {
      logic a;
      logic b;
      int   hold;
      int   exp_in;
      int   exp_out;
      logic exp_busy;
   } gvec_t;

   gvec_t gv [0:21];

   task automatic apply_vec(input int k);
      int ci, co;
      ci = cnt_in;
      co = cnt_out;
      Sens_a = gv[k].a;
      Sens_b = gv[k].b;
      repeat (gv[k].hold) @(negedge CLK);
      #1;
      chk($sformatf("vec%0d_in", k),   cnt_in - ci,     gv[k].exp_in);
      chk($sformatf("vec%0d_out", k),  cnt_out - co,    gv[k].exp_out);
      chk($sformatf("vec%0d_busy", k), int'(Gate_busy), int'(gv[k].exp_busy));
   endtask

   int c0, busy_cnt, h;

   initial begin
      // settle, entry, exit, abort, post-timeout clear + entry, reset passage, post-reset, entry
      gv[0]  = '{0, 0, 10, 0, 0, 0};
      gv[1]  = '{1, 0, 10, 0, 0, 1};
      gv[2]  = '{1, 1, 10, 0, 0, 1};
      gv[3]  = '{0, 1, 10, 0, 0, 1};
      gv[4]  = '{0, 0, 10, 1, 0, 0};
      gv[5]  = '{0, 1, 10, 0, 0, 1};
      gv[6]  = '{1, 1, 10, 0, 0, 1};
      gv[7]  = '{1, 0, 10, 0, 0, 1};
      gv[8]  = '{0, 0, 10, 0, 1, 0};
      gv[9]  = '{1, 0, 10, 0, 0, 1};
      gv[10] = '{0, 0, 10, 0, 0, 0};
      gv[11] = '{0, 0, 10, 0, 0, 0};
      gv[12] = '{1, 0, 10, 0, 0, 1};
      gv[13] = '{1, 1, 10, 0, 0, 1};
      gv[14] = '{0, 1, 10, 0, 0, 1};
      gv[15] = '{0, 0, 10, 1, 0, 0};
      gv[16] = '{1, 0, 10, 0, 0, 1};
      gv[17] = '{1, 1, 10, 0, 0, 1};
      gv[18] = '{1, 1, 10, 0, 0, 0};
      gv[19] = '{0, 1, 10, 0, 0, 0};
      gv[20] = '{0, 0, 10, 0, 0, 0};
      gv[21] = '{1, 0, 10, 0, 0, 1};

      // reset state
      repeat (3) @(negedge CLK);
      chk("rst_prs",  int'(Prs),       0);
      chk("rst_in",   int'(Car_in),    0);
      chk("rst_out",  int'(Car_out),   0);
      chk("rst_busy", int'(Gate_busy), 0);
      RST = 1'b1;
      repeat (10) @(negedge CLK);

      // clean press on button 2: pulse exactly DB+3 edges later
      Prs_raw[2] = 1'b1;
      repeat (DB + 2) @(posedge CLK);
      #1 chk("t1_before", int'(Prs), 0);
      @(posedge CLK);
      #1 chk("t1_pulse", int'(Prs), 3'b010);
      @(posedge CLK);
      #1 chk("t1_after", int'(Prs), 0);
      c0 = cnt_p[2];
      repeat (12) @(negedge CLK);
      Prs_raw[2] = 1'b0;
      repeat (15) @(negedge CLK);
      chk("t1_no_extra", cnt_p[2] - c0, 0);

      // bounce on button 1, then a stable rise
      c0 = cnt_p[1];
      for (int k = 0; k < 12; k++) begin
         Prs_raw[1] = ((k % 4) < 2);
         @(negedge CLK);
      end
      Prs_raw[1] = 1'b1;
      h = cyc;
      repeat (20) @(negedge CLK);
      chk("t2_count", cnt_p[1] - c0, 1);
      chk("t2_latency", last_p1 - h, DB + 3);
      Prs_raw[1] = 1'b0;
      repeat (15) @(negedge CLK);

      // simultaneous presses on buttons 1 and 3
      c0 = cnt_p[1] + cnt_p[3];
      Prs_raw = 3'b101;
      repeat (15) @(negedge CLK);
      Prs_raw = 3'b000;
      repeat (15) @(negedge CLK);
      chk("t_simul_count", cnt_p[1] + cnt_p[3] - c0, 2);

      // entry, exit, abort
      for (int k = 0; k <= 10; k++) apply_vec(k);

      // timeout: blocked outer sensor keeps the FSM busy for TO cycles only
      c0 = cnt_in + cnt_out;
      busy_cnt = 0;
      Sens_a = 1'b1;
      Sens_b = 1'b0;
      repeat (100) begin
         @(negedge CLK);
         #1 busy_cnt += int'(Gate_busy);
      end
      chk("t5_busy_cycles", busy_cnt, TO);
      chk("t5_no_pulse", cnt_in + cnt_out - c0, 0);
      for (int k = 11; k <= 15; k++) apply_vec(k);

      // reset in the middle of an entry
      apply_vec(16);
      apply_vec(17);
      #2 RST = 1'b0;
      #1;
      chk("t6_async_busy", int'(Gate_busy), 0);
      chk("t6_async_prs",  int'(Prs),       0);
      chk("t6_async_in",   int'(Car_in),    0);
      chk("t6_async_out",  int'(Car_out),   0);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      for (int k = 18; k <= 21; k++) apply_vec(k);
      apply_vec(13);
      apply_vec(14);
      apply_vec(15);

      // randomized stimulus, checked every cycle by the model
      for (int it = 0; it < 200; it++) begin
         Prs_raw = 3'($urandom);
         if ($urandom_range(0, 2) != 0) {Sens_a, Sens_b} = 2'($urandom);
         h = $urandom_range(1, 14);
         repeat (h) @(negedge CLK);
         if ($urandom_range(0, 59) == 0) begin
            #2 RST = 1'b0;
            @(negedge CLK);
            RST = 1'b1;
         end
      end
      Prs_raw = '0;
      Sens_a  = 1'b0;
      Sens_b  = 1'b0;
      repeat (20) @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/parking_input_conditioner.md
Name: parking_input_conditioner

Overview:
Front-end conditioning stage for the parking-lot controller. It takes raw, asynchronous push-button and gate-sensor signals and produces clean single-cycle event pulses: `Prs[3:1]` for passcode button presses, and `Car_in`/`Car_out` for cars passing the gate. These outputs drive the passcode/occupancy counter directly. The block contains input synchronizers, per-input debouncers, rising-edge pulse generators, and an FSM that determines car direction from two gate sensors.

Parameters:
DB_CYCLES, 16, consecutive stable cycles required before a debounced value changes (minimum 2)
TIMEOUT_CYCLES, 1024, maximum cycles the gate FSM may remain in any one mid-passage state before aborting

Ports:
CLK  input  1  system clock; all state on rising edge
RST  input  1  reset, asynchronous, active-low
Prs_raw  input  3 [3:1]  raw passcode buttons, active-high, asynchronous
Sens_a  input  1  outer gate sensor, high = beam blocked, asynchronous
Sens_b  input  1  inner gate sensor, high = beam blocked, asynchronous
Prs  output  3 [3:1]  one-cycle pulse per debounced button press
Car_in  output  1  one-cycle pulse when a complete entry is detected
Car_out  output  1  one-cycle pulse when a complete exit is detected
Gate_busy  output  1  high while a passage is in progress (FSM in any IN_* or OUT_* state)

Behaviour:
- Reset (RST=0, asynchronous):
  - All outputs go to 0 immediately.
  - Synchronizer flops, debounced values, and counters clear to 0.
  - The FSM enters WAIT_CLEAR.
- Synchronizer: two flops on each of the 5 raw inputs.
- Debouncer, one per input:
  - Counter increments while the synchronized value differs from the debounced value, and clears whenever they match.
  - When the mismatch has lasted DB_CYCLES consecutive cycles, the debounced value flips and the counter clears.
  - Any glitch shorter than DB_CYCLES is ignored.
- Button pulses:
  - `Prs[i]` is a registered pulse asserted for exactly 1 cycle, on the edge after debounced button i rises.
  - End-to-end latency from a clean raw rise to `Prs[i]` high is DB_CYCLES+3 edges.
  - There is no pulse on release.
  - Buttons are independent; simultaneous presses pulse in the same cycle.
  - A held button produces exactly one pulse.
- Gate FSM, on debounced a/b:
  - WAIT_CLEAR: go to IDLE when a=0 and b=0.
  - IDLE:
    - a=1, b=0 → IN_A
    - a=0, b=1 → OUT_B
    - a=1, b=1 → WAIT_CLEAR (ambiguous, no pulse)
  - IN_A:
    - b=1 → IN_AB
    - a=0, b=0 → IDLE (car backed off, no pulse)
  - IN_AB:
    - a=0, b=1 → IN_B
    - a=1, b=0 → IN_A
    - a=0, b=0 → WAIT_CLEAR
  - IN_B:
    - a=0, b=0 → IDLE, with `Car_in` registered high for 1 cycle
    - a=1 → IN_AB
  - OUT_B, OUT_AB, OUT_A: mirror of the IN_* states with a and b swapped; completion asserts `Car_out`.
  - Timeout:
    - A timeout counter clears on every state change and counts while in any IN_*/OUT_* state.
    - After TIMEOUT_CYCLES cycles in the same state, the FSM moves to WAIT_CLEAR with no pulse.
  - Output exclusivity: `Car_in` and `Car_out` are never high in the same cycle, and each is high for at most 1 consecutive cycle.
  - Latency: the car pulse appears 1 edge after the final debounced transition.
- Reset mid-passage:
  - The FSM returns to WAIT_CLEAR, so no pulse is emitted for the interrupted car.
  - A sensor still blocked after reset produces no event until both sensors clear.
- `Gate_busy` is a combinational decode of the FSM state: 1 in IN_A/IN_AB/IN_B/OUT_B/OUT_AB/OUT_A, 0 in IDLE/WAIT_CLEAR.

Test Plan:
All scenarios run with DB_CYCLES=4 and TIMEOUT_CYCLES=64.
1. Clean press: `Prs_raw[2]` 0→1, held 20 cycles → `Prs=3'b010` for exactly 1 cycle, 7 edges after the change; no further pulse; no pulse on release.
2. Bounce rejection: `Prs_raw[1]` toggles every 2 cycles for 12 cycles, then holds 1 → exactly one `Prs[1]` pulse, occurring 7 edges after the final stable rise.
3. Entry: after a 10-cycle settle, apply sequence ab = 10, 11, 01, 00, each held 10 cycles → one `Car_in` pulse, `Car_out`=0; `Gate_busy` high from IN_A until the pulse cycle.
4. Exit and abort:
   - ab = 01, 11, 10, 00 → one `Car_out`.
   - Then ab = 10, 00 → no pulse, FSM back in IDLE.
5. Timeout: ab = 10 held 100 cycles → `Gate_busy` drops after 64 cycles in IN_A with no pulse. Then 00, then a full entry → one `Car_in`.
6. Reset mid-passage:
   - Drive ab = 10, 11, then RST=0 for 3 cycles → all outputs 0 asynchronously.
   - Release with ab = 11, then 01, 00 → no `Car_in`.
   - A subsequent full entry → one `Car_in`.
